// File: rtl/booth_prod_accumulator.sv
// Sums GROUP_N signed Booth products into a group result on a valid/ready register.
// Define BOOTH_ACC_SAT_EN for saturating adds and the sticky sat_flag output.
module booth_prod_accumulator #(
  parameter int PROD_W  = 8,
  parameter int GROUP_N = 4,
  parameter int ACC_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       prod_valid,
  input  logic [PROD_W-1:0]          prod,
  output logic [ACC_W-1:0]           acc_out,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef BOOTH_ACC_SAT_EN
  output logic                       sat_flag,
`endif
  output logic [$clog2(GROUP_N)-1:0] fill_cnt,
  output logic                       drop_err
);

  localparam int CNT_W = $clog2(GROUP_N);

  typedef enum logic {EMPTY, FILL} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             last;
  logic             done;

  assign ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign last = (state == FILL) && (fill_cnt == CNT_W'(GROUP_N-1));
  assign done = prod_valid && !clr && last;

`ifdef BOOTH_ACC_SAT_EN
  logic [ACC_W:0] wide;
  logic           ovf;

  // Overflow when the extra sign bit disagrees with the result sign.
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    sum  = wide[ACC_W-1:0];
    if (ovf)
      sum = {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_flag <= 1'b0;
    else if (clr)
      sat_flag <= 1'b0;
    else if (prod_valid && ovf)
      sat_flag <= 1'b1;
  end
`else
  assign sum = acc + ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      acc       <= '0;
      fill_cnt  <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      if (clr) begin
        state    <= EMPTY;
        acc      <= '0;
        fill_cnt <= '0;
        drop_err <= 1'b0;
      end else if (prod_valid) begin
        unique case (state)
          EMPTY: begin
            state    <= FILL;
            acc      <= sum;
            fill_cnt <= CNT_W'(1);
          end
          FILL: begin
            if (last) begin
              state    <= EMPTY;
              acc      <= '0;
              fill_cnt <= '0;
            end else begin
              acc      <= sum;
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
          default: state <= EMPTY;
        endcase
        // A finished group with a stalled result cannot be held.
        if (done && out_valid && !out_ready)
          drop_err <= 1'b1;
      end

      if (done && (!out_valid || out_ready)) begin
        acc_out   <= sum;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
